// File: rtl/ewtag_offset_ctrl.sv
// Event Window tag offset controller: picks the EW offset (DCS, SERIAL or AUTO-captured),
// freezes it for the spill, converts heartbeat tags to EW tags and counts tag discontinuities.
//
// state | meaning
// IDLE  | between spills; non-AUTO offset tracks its source, heartbeats ignored
// ARMED | AUTO spill started, waiting for the first heartbeat to capture the offset
// RUN   | offset frozen; heartbeats converted and continuity-checked
module ewtag_offset_ctrl #(
    parameter int TAG_W    = 48,
    parameter int ERRCNT_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          mode_sel,
    input  logic [TAG_W-1:0]    serial_offset,
    input  logic [TAG_W-1:0]    run_offset,
    input  logic                spill_start,
    input  logic                spill_end,
    input  logic                hb_valid,
    input  logic [TAG_W-1:0]    hb_tag,
    input  logic                clear_err,
    output logic [TAG_W-1:0]    ewtag_offset,
    output logic [TAG_W-1:0]    ewtag,
    output logic                ewtag_valid,
    output logic                underflow,
    output logic [1:0]          state,
    output logic [ERRCNT_W-1:0] seq_err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_RUN   = 2'b10
    } state_t;

    localparam logic [1:0] MODE_SERIAL = 2'b01;
    localparam logic [1:0] MODE_AUTO   = 2'b10;

    state_t                state_q, state_d;
    logic [TAG_W-1:0]      offset_q, offset_d;
    logic [TAG_W-1:0]      ewtag_q, ewtag_d;
    logic                  ewtag_valid_q, ewtag_valid_d;
    logic                  underflow_q, underflow_d;
    logic [TAG_W-1:0]      prev_tag_q, prev_tag_d;
    logic                  first_hb_q, first_hb_d;
    logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic                  auto_mode;
    logic [TAG_W-1:0]      src_offset;
    logic                  seq_err;

    // Reserved mode 11 falls through to the DCS source.
    always_comb begin
        auto_mode  = (mode_sel == MODE_AUTO);
        src_offset = (mode_sel == MODE_SERIAL) ? serial_offset : run_offset - TAG_W'(1);
    end

    always_comb begin
        state_d       = state_q;
        offset_d      = offset_q;
        ewtag_d       = ewtag_q;
        ewtag_valid_d = 1'b0;
        underflow_d   = underflow_q;
        prev_tag_d    = prev_tag_q;
        first_hb_d    = first_hb_q;
        seq_err       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!auto_mode) begin
                    offset_d = src_offset;
                end
                if (spill_start && !spill_end) begin
                    first_hb_d = 1'b1;
                    state_d    = auto_mode ? ST_ARMED : ST_RUN;
                end
            end
            ST_ARMED: begin
                if (hb_valid) begin
                    offset_d      = hb_tag - TAG_W'(1);
                    ewtag_d       = TAG_W'(1);
                    ewtag_valid_d = 1'b1;
                    underflow_d   = 1'b0;
                    prev_tag_d    = hb_tag;
                    first_hb_d    = 1'b0;
                    state_d       = ST_RUN;
                end
            end
            ST_RUN: begin
                if (hb_valid) begin
                    ewtag_d       = hb_tag - offset_q;
                    ewtag_valid_d = 1'b1;
                    underflow_d   = (hb_tag < offset_q);
                    seq_err       = !first_hb_q && (hb_tag != prev_tag_q + TAG_W'(1));
                    prev_tag_d    = hb_tag;
                    first_hb_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Spill boundaries inside a spill act after the same-cycle heartbeat was handled.
        if (state_q == ST_ARMED || state_q == ST_RUN) begin
            if (spill_end) begin
                state_d = ST_IDLE;
            end else if (spill_start) begin
                first_hb_d = 1'b1;
                if (auto_mode) begin
                    state_d = ST_ARMED;
                end else begin
                    offset_d = src_offset;
                    state_d  = ST_RUN;
                end
            end
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clear_err) begin
            err_cnt_d = '0;
        end else if (seq_err && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERRCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            offset_q      <= '0;
            ewtag_q       <= '0;
            ewtag_valid_q <= 1'b0;
            underflow_q   <= 1'b0;
            prev_tag_q    <= '0;
            first_hb_q    <= 1'b1;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            offset_q      <= offset_d;
            ewtag_q       <= ewtag_d;
            ewtag_valid_q <= ewtag_valid_d;
            underflow_q   <= underflow_d;
            prev_tag_q    <= prev_tag_d;
            first_hb_q    <= first_hb_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign ewtag_offset = offset_q;
    assign ewtag        = ewtag_q;
    assign ewtag_valid  = ewtag_valid_q;
    assign underflow    = underflow_q;
    assign state        = state_q;
    assign seq_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_ewtag_offset_ctrl.sv
// Bench for ewtag_offset_ctrl: spill-level reference model checked every cycle, plus
// directed scenarios with literal expectations. A second instance has a 2-bit error counter.
module tb_ewtag_offset_ctrl;

    localparam int TAG_W = 48;
    typedef logic [TAG_W-1:0] tag_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  mode_sel;
    tag_t        serial_offset, run_offset, hb_tag;
    logic        spill_start, spill_end, hb_valid, clear_err;

    tag_t        ewtag_offset, ewtag;
    logic        ewtag_valid, underflow;
    logic [1:0]  state;
    logic [15:0] seq_err_cnt;

    tag_t        ewtag_offset_s, ewtag_s;
    logic        ewtag_valid_s, underflow_s;
    logic [1:0]  state_s;
    logic [1:0]  seq_err_cnt_s;

    ewtag_offset_ctrl #(.TAG_W(TAG_W), .ERRCNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .mode_sel(mode_sel), .serial_offset(serial_offset),
        .run_offset(run_offset), .spill_start(spill_start), .spill_end(spill_end),
        .hb_valid(hb_valid), .hb_tag(hb_tag), .clear_err(clear_err),
        .ewtag_offset(ewtag_offset), .ewtag(ewtag), .ewtag_valid(ewtag_valid),
        .underflow(underflow), .state(state), .seq_err_cnt(seq_err_cnt)
    );

    ewtag_offset_ctrl #(.TAG_W(TAG_W), .ERRCNT_W(2)) dut_small (
        .clk(clk), .reset_n(reset_n), .mode_sel(mode_sel), .serial_offset(serial_offset),
        .run_offset(run_offset), .spill_start(spill_start), .spill_end(spill_end),
        .hb_valid(hb_valid), .hb_tag(hb_tag), .clear_err(clear_err),
        .ewtag_offset(ewtag_offset_s), .ewtag(ewtag_s), .ewtag_valid(ewtag_valid_s),
        .underflow(underflow_s), .state(state_s), .seq_err_cnt(seq_err_cnt_s)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: spill phase (0 idle, 1 waiting for AUTO capture, 2 running)
    // and an unbounded discontinuity count that is clipped to each counter width.
    int   m_phase = 0;
    tag_t m_off   = '0;
    tag_t m_ewtag = '0;
    tag_t m_prev  = '0;
    bit   m_valid = 1'b0;
    bit   m_uf    = 1'b0;
    bit   m_first = 1'b1;
    int   m_raw   = 0;

    function automatic int clip(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_phase = 0; m_off = '0; m_ewtag = '0; m_prev = '0;
                m_valid = 1'b0; m_uf = 1'b0; m_first = 1'b1; m_raw = 0;
            end else begin
                tag_t src;
                bit   is_auto;
                src     = (mode_sel == 2'b01) ? serial_offset : run_offset - tag_t'(1);
                is_auto = (mode_sel == 2'b10);
                m_valid = 1'b0;
                if (m_phase == 0) begin
                    if (!is_auto) m_off = src;
                    if (spill_start && !spill_end) begin
                        m_first = 1'b1;
                        m_phase = is_auto ? 1 : 2;
                    end
                end else begin
                    if (hb_valid) begin
                        if (m_phase == 1) begin
                            m_off   = hb_tag - tag_t'(1);
                            m_ewtag = tag_t'(1);
                            m_uf    = 1'b0;
                        end else begin
                            if (!m_first && hb_tag != m_prev + tag_t'(1)) m_raw++;
                            m_ewtag = hb_tag - m_off;
                            m_uf    = (hb_tag < m_off);
                        end
                        m_valid = 1'b1;
                        m_prev  = hb_tag;
                        m_first = 1'b0;
                        m_phase = 2;
                    end
                    if (spill_end) begin
                        m_phase = 0;
                    end else if (spill_start) begin
                        m_first = 1'b1;
                        if (is_auto) m_phase = 1;
                        else begin
                            m_off   = src;
                            m_phase = 2;
                        end
                    end
                end
                if (clear_err) m_raw = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_state", state, 64'(m_phase));
            chk("model_offset", ewtag_offset, m_off);
            chk("model_valid", ewtag_valid, m_valid);
            if (m_valid) begin
                chk("model_ewtag", ewtag, m_ewtag);
                chk("model_underflow", underflow, m_uf);
            end
            chk("model_errcnt", seq_err_cnt, 64'(clip(m_raw, 65535)));
            chk("model_errcnt_w2", seq_err_cnt_s, 64'(clip(m_raw, 3)));
            chk("model_state_w2", state_s, 64'(m_phase));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_hb(input tag_t t);
        hb_valid = 1'b1;
        hb_tag   = t;
        tick();
        hb_valid = 1'b0;
    endtask

    task automatic start_spill();
        spill_start = 1'b1;
        tick();
        spill_start = 1'b0;
    endtask

    task automatic end_spill();
        spill_end = 1'b1;
        tick();
        spill_end = 1'b0;
    endtask

    initial begin
        tag_t seq_a [4];
        tag_t seq_b [4];
        seq_a = '{48'd10, 48'd11, 48'd13, 48'd13};
        seq_b = '{48'd100, 48'd200, 48'd300, 48'd400};

        reset_n = 1'b0; mode_sel = 2'b00; serial_offset = '0; run_offset = '0;
        hb_tag = '0; spill_start = 1'b0; spill_end = 1'b0; hb_valid = 1'b0; clear_err = 1'b0;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_offset", ewtag_offset, 0);
        chk("rst_errcnt", seq_err_cnt, 0);
        reset_n = 1'b1;
        tick();

        // DCS
        mode_sel = 2'b00; run_offset = 48'd100;
        tick();
        chk("dcs_idle_offset", ewtag_offset, 99);
        start_spill();
        chk("dcs_state_run", state, 2);
        for (int i = 0; i < 4; i++) begin
            pulse_hb(tag_t'(100 + i));
            chk("dcs_ewtag", ewtag, 64'(i + 1));
            chk("dcs_valid", ewtag_valid, 1);
        end
        tick();
        chk("dcs_valid_low", ewtag_valid, 0);
        chk("dcs_errcnt", seq_err_cnt, 0);
        end_spill();
        chk("dcs_idle", state, 0);

        // AUTO
        mode_sel = 2'b10;
        start_spill();
        chk("auto_armed", state, 1);
        chk("auto_hold_offset", ewtag_offset, 99);
        pulse_hb(48'd5000);
        chk("auto_run", state, 2);
        chk("auto_offset", ewtag_offset, 4999);
        chk("auto_ewtag1", ewtag, 1);
        pulse_hb(48'd5001);
        chk("auto_ewtag2", ewtag, 2);
        end_spill();

        // Freeze and discontinuities
        mode_sel = 2'b01; serial_offset = 48'd7;
        start_spill();
        chk("ser_offset", ewtag_offset, 7);
        serial_offset = 48'd1000; mode_sel = 2'b00; run_offset = 48'd50;
        tick();
        chk("freeze_offset", ewtag_offset, 7);
        for (int i = 0; i < 4; i++) begin
            pulse_hb(seq_a[i]);
            if (i == 0) chk("skip_ewtag_first", ewtag, 3);
        end
        chk("skip_errcnt", seq_err_cnt, 2);
        clear_err = 1'b1;
        pulse_hb(48'd20);
        clear_err = 1'b0;
        chk("clear_priority", seq_err_cnt, 0);
        chk("clear_ewtag", ewtag, 13);
        end_spill();

        // Wrap and saturation
        mode_sel = 2'b01; serial_offset = 48'd8;
        start_spill();
        pulse_hb(48'd3);
        chk("wrap_ewtag", ewtag, 64'h0000_FFFF_FFFF_FFFB);
        chk("wrap_underflow", underflow, 1);
        for (int i = 0; i < 4; i++) begin
            pulse_hb(seq_b[i]);
            if (i == 0) begin
                chk("nowrap_ewtag", ewtag, 92);
                chk("nowrap_underflow", underflow, 0);
            end
        end
        chk("sat_w16", seq_err_cnt, 4);
        chk("sat_w2", seq_err_cnt_s, 3);
        end_spill();

        // Simultaneity and DCS edge values
        spill_start = 1'b1; spill_end = 1'b1;
        tick();
        spill_start = 1'b0; spill_end = 1'b0;
        chk("start_end_idle", state, 0);
        mode_sel = 2'b11; run_offset = 48'd200;
        tick();
        chk("reserved_is_dcs", ewtag_offset, 199);
        mode_sel = 2'b00; run_offset = 48'd0;
        tick();
        chk("dcs_zero_offset", ewtag_offset, 64'h0000_FFFF_FFFF_FFFF);
        start_spill();
        pulse_hb(48'd5);
        chk("allones_ewtag", ewtag, 6);
        chk("allones_underflow", underflow, 1);
        hb_valid = 1'b1; hb_tag = 48'd6; spill_end = 1'b1;
        tick();
        hb_valid = 1'b0; spill_end = 1'b0;
        chk("end_hb_valid", ewtag_valid, 1);
        chk("end_hb_ewtag", ewtag, 7);
        chk("end_hb_idle", state, 0);
        tick();
        chk("end_valid_once", ewtag_valid, 0);
        pulse_hb(48'd7);
        chk("idle_hb_ignored", ewtag_valid, 0);
        chk("idle_errcnt", seq_err_cnt, 4);

        // Restart inside RUN: same-cycle heartbeat uses the old offset
        mode_sel = 2'b01; serial_offset = 48'd10;
        start_spill();
        pulse_hb(48'd20);
        chk("restart_pre_ewtag", ewtag, 10);
        serial_offset = 48'd30; hb_valid = 1'b1; hb_tag = 48'd21; spill_start = 1'b1;
        tick();
        hb_valid = 1'b0; spill_start = 1'b0;
        chk("restart_old_offset", ewtag, 11);
        chk("restart_new_offset", ewtag_offset, 30);
        pulse_hb(48'd40);
        chk("restart_ewtag", ewtag, 10);
        chk("restart_first_hb", seq_err_cnt, 4);

        // Asynchronous reset in the middle of RUN
        hb_valid = 1'b1; hb_tag = 48'd41;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_state", state, 0);
        chk("async_offset", ewtag_offset, 0);
        chk("async_ewtag", ewtag, 0);
        chk("async_valid", ewtag_valid, 0);
        chk("async_underflow", underflow, 0);
        chk("async_errcnt", seq_err_cnt, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            hb_valid = ~hb_valid; hb_tag = tag_t'(50 + i); spill_start = 1'b1;
            tick();
            chk("rst_hold_state", state, 0);
            chk("rst_hold_valid", ewtag_valid, 0);
        end
        hb_valid = 1'b0; spill_start = 1'b0; reset_n = 1'b1;
        tick();
        chk("post_rst_state", state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
